mmult_stream_multicol: RTL

Successor matrix engine that computes R = (X·Yc) >> RESULT_SHIFT for every column c of a Y block, not just one column.
- X is an M×N operand held in synchronous-read RAM.
- Y is an N×P operand held in synchronous-read RAM, with a skipped bias-row base and a configurable row stride.
- Sits between the X/Y operand RAMs and the result consumer (RES RAM writer / next layer).
- Results stream out column-major with row/column tags, at one multiply-accumulate (MAC) per cycle and no bubbles between rows or columns.

---
 rtl/mmult_stream_multicol.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mmult_stream_multicol.sv
// Streams R = (X*Yc) >> RESULT_SHIFT for every Y column c, one MAC per cycle, column-major.
// Optional clamp-to-max with a res_sat flag when MMULT_SAT_EN is defined.
module mmult_stream_multicol #(
   parameter int WIDTH        = 8,
   parameter int M            = 64,
   parameter int N            = 8,
   parameter int P            = 2,
   parameter int X_DEPTH_BITS = 9,
   parameter int Y_DEPTH_BITS = 5,
   parameter int Y_ROW_STRIDE = 2,
   parameter int Y_ROW_BASE   = 1,
   parameter int RESULT_SHIFT = 8,
   parameter int ACC_WIDTH    = 32,
   localparam int RW = (M > 1) ? $clog2(M) : 1,
   localparam int CW = (P > 1) ? $clog2(P) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    res_valid,
   output logic [WIDTH-1:0]        res_data,
`ifdef MMULT_SAT_EN
   output logic                    res_sat,
`endif
   output logic [RW-1:0]           res_row,
   output logic [CW-1:0]           res_col,
   output logic                    X_read_en,
   output logic [X_DEPTH_BITS-1:0] X_read_address,
   input  logic [WIDTH-1:0]        X_read_data,
   output logic                    Y_read_en,
   output logic [Y_DEPTH_BITS-1:0] Y_read_address,
   input  logic [WIDTH-1:0]        Y_read_data
);
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   state_t state_q, state_d;

   logic [KW-1:0] k_q, k_d;
   logic [RW-1:0] i_q, i_d;
   logic [CW-1:0] c_q, c_d;
   logic          k_end, i_end, c_end, last_pair, issue;

   // [0] travels with the address, [1] with the returning RAM data
   logic [1:0]         vld_pipe_q, first_pipe_q, kend_pipe_q, last_pipe_q;
   logic [1:0][RW-1:0] row_pipe_q;
   logic [1:0][CW-1:0] col_pipe_q;

   logic [X_DEPTH_BITS-1:0] xaddr_d;
   logic [Y_DEPTH_BITS-1:0] yaddr_d;
   logic [2*WIDTH-1:0]      prod;
   logic [ACC_WIDTH-1:0]    acc_q, acc_sum;
   logic [WIDTH-1:0]        res_d;
   logic                    res_fire;
`ifdef MMULT_SAT_EN
   logic                    ovf;
`endif

   assign k_end     = (k_q == KW'(N - 1));
   assign i_end     = (i_q == RW'(M - 1));
   assign c_end     = (c_q == CW'(P - 1));
   assign last_pair = k_end && i_end && c_end;
   assign issue     = (state_q == ISSUE);

   assign xaddr_d = X_DEPTH_BITS'(i_q) * X_DEPTH_BITS'(N) + X_DEPTH_BITS'(k_q);
   assign yaddr_d = (Y_DEPTH_BITS'(Y_ROW_BASE) + Y_DEPTH_BITS'(k_q)) * Y_DEPTH_BITS'(Y_ROW_STRIDE)
                    + Y_DEPTH_BITS'(c_q);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      i_d     = i_q;
      c_d     = c_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = ISSUE;
            k_d     = '0;
            i_d     = '0;
            c_d     = '0;
         end
         ISSUE: begin
            k_d = k_end ? '0 : k_q + KW'(1);
            if (k_end) begin
               i_d = i_end ? '0 : i_q + RW'(1);
               if (i_end) c_d = c_q + CW'(1);
            end
            if (last_pair) state_d = DRAIN;
         end
         DRAIN: if (vld_pipe_q[1] && last_pipe_q[1]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // k==0 reloads the accumulator so dot products run back to back
   assign prod     = (2*WIDTH)'(X_read_data) * (2*WIDTH)'(Y_read_data);
   assign acc_sum  = (first_pipe_q[1] ? '0 : acc_q) + ACC_WIDTH'(prod);
   assign res_fire = vld_pipe_q[1] && kend_pipe_q[1];

   always_comb begin
      res_d = WIDTH'(acc_sum >> RESULT_SHIFT);
`ifdef MMULT_SAT_EN
      ovf = (acc_sum >> (RESULT_SHIFT + WIDTH)) != '0;
      if (ovf) res_d = '1;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         k_q            <= '0;
         i_q            <= '0;
         c_q            <= '0;
         busy           <= 1'b0;
         X_read_en      <= 1'b0;
         Y_read_en      <= 1'b0;
         X_read_address <= '0;
         Y_read_address <= '0;
         vld_pipe_q     <= '0;
         first_pipe_q   <= '0;
         kend_pipe_q    <= '0;
         last_pipe_q    <= '0;
         row_pipe_q     <= '0;
         col_pipe_q     <= '0;
         acc_q          <= '0;
         res_valid      <= 1'b0;
         res_data       <= '0;
         res_row        <= '0;
         res_col        <= '0;
         done           <= 1'b0;
`ifdef MMULT_SAT_EN
         res_sat        <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         i_q       <= i_d;
         c_q       <= c_d;
         busy      <= (state_q != IDLE);
         X_read_en <= issue;
         Y_read_en <= issue;
         if (issue) begin
            X_read_address <= xaddr_d;
            Y_read_address <= yaddr_d;
         end
         vld_pipe_q   <= {vld_pipe_q[0], issue};
         first_pipe_q <= {first_pipe_q[0], k_q == '0};
         kend_pipe_q  <= {kend_pipe_q[0], k_end};
         last_pipe_q  <= {last_pipe_q[0], last_pair};
         row_pipe_q   <= {row_pipe_q[0], i_q};
         col_pipe_q   <= {col_pipe_q[0], c_q};
         if (vld_pipe_q[1]) acc_q <= acc_sum;
         res_valid <= res_fire;
         done      <= vld_pipe_q[1] && last_pipe_q[1];
         if (res_fire) begin
            res_data <= res_d;
            res_row  <= row_pipe_q[1];
            res_col  <= col_pipe_q[1];
         end
`ifdef MMULT_SAT_EN
         res_sat <= res_fire && ovf;
`endif
      end
   end
endmodule
